// File: rtl/ps2_scan_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: prefix codes,
// frame length, receiver FSM states and the FIFO entry layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    PUSH
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

endpackage

// File: rtl/ps2_scan_rx_code_fifo.sv
// Small synchronous FIFO holding decoded scan codes with their prefix flags.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        ck,
  input  logic                        reset_n,
  input  logic                        push,
  input  ps2_entry_t                  push_data,
  input  logic                        pop,
  output ps2_entry_t                  head,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  ps2_entry_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_reg;
  // Head is forced to zero while empty so the outputs read 0 after reset.
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Storage write; contents need no reset because the level gates the head.
  always_ff @(posedge ck) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, frames
// 11-bit words on filtered clock falling edges, folds E0/F0 prefixes into
// flags and queues decoded codes in a valid/ready FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN (enables odd-parity checking).
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        ck,
  input  logic                        reset_n,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [7:0]                  rd_code,
  output logic                        rd_brk,
  output logic                        rd_ext,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        timeout_err,
  output logic                        overflow
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W       = $clog2(FILTER_LEN + 1);
  localparam int BC_W        = $clog2(PS2_FRAME_BITS + 1);

  logic [1:0] raw_line;
  logic [1:0] filt_line;
  assign raw_line = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic             meta_reg;
      logic             sync_reg;
      logic             filt_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Two-flop synchroniser followed by a run-length filter: the filtered
      // value follows the input only after FILTER_LEN consecutive differing samples.
      always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= raw_line[gi];
          sync_reg <= meta_reg;
          if (sync_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
            filt_reg <= sync_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign filt_line[gi] = filt_reg;
    end
  endgenerate

  logic filt_clk;
  logic filt_data;
  logic clk_prev_reg;
  logic bit_event;
  assign filt_clk  = filt_line[0];
  assign filt_data = filt_line[1];
  assign bit_event = clk_prev_reg && !filt_clk;

  ps2_state_t                state_reg, state_next;
  logic [PS2_FRAME_BITS-1:0] shift_reg, shift_next;
  logic [BC_W-1:0]           count_reg, count_next;
  logic [TMO_W-1:0]          tmo_reg, tmo_next;
  logic                      ext_reg, ext_next;
  logic                      brk_reg, brk_next;
  logic                      frame_err_reg, frame_err_next;
  logic                      timeout_err_reg, timeout_err_next;
  logic                      overflow_reg;
  logic                      push_req;
  logic                      parity_ok;
  logic [7:0]                code;

  // Frame layout after 11 LSB-first shifts: [0] start, [8:1] code, [9] parity, [10] stop.
  assign code = shift_reg[8:1];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_reg[9:1];
`else
  logic unused_parity;
  assign parity_ok     = 1'b1;
  assign unused_parity = shift_reg[9];
`endif

  // Filtered clock history for falling-edge detection.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) clk_prev_reg <= 1'b1;
    else          clk_prev_reg <= filt_clk;
  end

  // Receiver state and datapath registers.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      count_reg       <= '0;
      tmo_reg         <= '0;
      ext_reg         <= 1'b0;
      brk_reg         <= 1'b0;
      frame_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      count_reg       <= count_next;
      tmo_reg         <= tmo_next;
      ext_reg         <= ext_next;
      brk_reg         <= brk_next;
      frame_err_reg   <= frame_err_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Next-state logic: framing, inter-bit timeout, frame checks and prefix folding.
  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    count_next       = count_reg;
    tmo_next         = '0;
    ext_next         = ext_reg;
    brk_next         = brk_reg;
    frame_err_next   = 1'b0;
    timeout_err_next = 1'b0;
    push_req         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bit_event && !filt_data) begin
          shift_next = {1'b0, shift_reg[PS2_FRAME_BITS-1:1]};
          count_next = BC_W'(1);
          state_next = RECV;
        end
      end
      RECV: begin
        if (bit_event) begin
          shift_next = {filt_data, shift_reg[PS2_FRAME_BITS-1:1]};
          count_next = count_reg + BC_W'(1);
          if (count_reg == BC_W'(PS2_FRAME_BITS - 1)) state_next = CHECK;
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYC)) begin
          timeout_err_next = 1'b1;
          ext_next         = 1'b0;
          brk_next         = 1'b0;
          state_next       = IDLE;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      CHECK: begin
        if (shift_reg[0] || !shift_reg[PS2_FRAME_BITS-1] || !parity_ok) begin
          frame_err_next = 1'b1;
          ext_next       = 1'b0;
          brk_next       = 1'b0;
          state_next     = IDLE;
        end else if (code == PS2_EXT_PREFIX) begin
          ext_next   = 1'b1;
          state_next = IDLE;
        end else if (code == PS2_BRK_PREFIX) begin
          brk_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = PUSH;
        end
      end
      PUSH: begin
        push_req   = 1'b1;
        ext_next   = 1'b0;
        brk_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  ps2_entry_t push_entry;
  ps2_entry_t head;
  logic       fifo_full;
  logic       pop;

  assign push_entry.ext  = ext_reg;
  assign push_entry.brk  = brk_reg;
  assign push_entry.code = code;
  assign pop             = rd_valid && rd_ready;

  ps2_code_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .ck        (ck),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  // Sticky overflow: a code was dropped because the FIFO was full with no pop.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n)                            overflow_reg <= 1'b0;
    else if (push_req && fifo_full && !pop)  overflow_reg <= 1'b1;
  end

  assign rd_valid    = (fifo_level != '0);
  assign rd_code     = head.code;
  assign rd_brk      = head.brk;
  assign rd_ext      = head.ext;
  assign frame_err   = frame_err_reg;
  assign timeout_err = timeout_err_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: stimulus pushes expected entries from a
// high-level model of the PS/2 prefix rules; a monitor pops and compares on
// every FIFO handshake.
module tb_ps2_scan_rx;

  localparam int CLK_HZ     = 10_000_000;
  localparam int CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int TIMEOUT_US = 20;
  localparam int FILTER_LEN = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = 20;
  localparam int IDLE_GAP   = 60;

  logic       ck;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_code;
  logic       rd_brk;
  logic       rd_ext;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  ps2_scan_rx #(
    .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ck(ck), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_code(rd_code),
    .rd_brk(rd_brk), .rd_ext(rd_ext), .fifo_level(fifo_level),
    .frame_err(frame_err), .timeout_err(timeout_err), .overflow(overflow)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int         tests = 0;
  int         fails = 0;
  int         n_fe = 0, n_to = 0, exp_fe = 0, exp_to = 0;
  logic [9:0] exp_q[$];
  bit         m_ext = 0, m_brk = 0, exp_ovf = 0;
  bit         ready_mode = 0;
  int         lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decides from the protocol rules what a frame produces.
  function automatic void model_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    bit ok;
    ok = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) ok = 0;
`endif
    if (!ok) begin
      exp_fe++;
      m_ext = 0;
      m_brk = 0;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1;
      else exp_q.push_back({m_ext, m_brk, c});
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^c) ^ bad_par;
    return {~bad_stop, par, c, 1'b0};
  endfunction

  // Drives nbits of a frame, device-style: data set while clock high, then clock falls.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch, output int l);
    l = -1;
    for (int b = 0; b < nbits; b++) begin
      ps2_data = bits[b];
      for (int i = 1; i <= HALF; i++) begin
        @(negedge ck);
        ps2_clk = (glitch && i == HALF/2) ? 1'b0 : 1'b1;
      end
      ps2_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        @(negedge ck);
        if (b == nbits-1 && l < 0 && rd_valid) l = i;
        ps2_clk = (glitch && i == HALF/2) ? 1'b1 : 1'b0;
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop,
                            input bit glitch, output int l);
    model_frame(c, bad_par, bad_stop);
    send_bits(mk_frame(c, bad_par, bad_stop), 11, glitch, l);
    ps2_data = 1'b1;
    repeat (IDLE_GAP) @(negedge ck);
  endtask

  task automatic set_ready(input logic v);
    @(posedge ck);
    #1 rd_ready = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < 2000) begin
      @(negedge ck);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s: drain timed out, %0d expected entries pending, rd_valid=%0b",
               name, exp_q.size(), rd_valid);
    end
  endtask

  // Random consumer back-pressure, changed just after the active edge.
  always @(posedge ck) begin
    #1;
    if (ready_mode) rd_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pulse widths, head stability under back-pressure, scoreboard pops.
  logic       prev_fe = 0, prev_to = 0, prev_hold = 0;
  logic [9:0] prev_head = '0;
  always @(negedge ck) begin
    logic [9:0] e;
    if (!reset_n) begin
      prev_fe   = 0;
      prev_to   = 0;
      prev_hold = 0;
    end else begin
      if (frame_err) begin
        n_fe++;
        tests++;
        if (prev_fe) begin
          fails++;
          $display("FAIL frame_err_width: got high on consecutive cycles, expected one-cycle pulse");
        end
      end
      if (timeout_err) begin
        n_to++;
        tests++;
        if (prev_to) begin
          fails++;
          $display("FAIL timeout_err_width: got high on consecutive cycles, expected one-cycle pulse");
        end
      end
      if (prev_hold) begin
        tests++;
        if ({rd_ext, rd_brk, rd_code} !== prev_head) begin
          fails++;
          $display("FAIL head_stable: got %0h expected %0h", {rd_ext, rd_brk, rd_code}, prev_head);
        end
      end
      if (rd_valid && rd_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_entry: got ext=%0b brk=%0b code=%0h expected none",
                   rd_ext, rd_brk, rd_code);
        end else begin
          e = exp_q.pop_front();
          if ({rd_ext, rd_brk, rd_code} !== e)
            begin
              fails++;
              $display("FAIL entry: got ext=%0b brk=%0b code=%0h expected ext=%0b brk=%0b code=%0h",
                       rd_ext, rd_brk, rd_code, e[9], e[8], e[7:0]);
            end
          else
            $display("[TB] popped ext=%0b brk=%0b code=%0h", rd_ext, rd_brk, rd_code);
        end
      end
      prev_fe   = frame_err;
      prev_to   = timeout_err;
      prev_hold = rd_valid && !rd_ready;
      prev_head = {rd_ext, rd_brk, rd_code};
    end
  end

  logic [7:0] ovf_codes [5];
  initial begin
    ovf_codes[0] = 8'h15; ovf_codes[1] = 8'h2D; ovf_codes[2] = 8'h3C;
    ovf_codes[3] = 8'h4B; ovf_codes[4] = 8'h5A;

    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_ready = 1'b0;
    repeat (5) @(negedge ck);
    @(posedge ck);
    #1 reset_n = 1'b1;
    @(negedge ck);
    check("reset_rd_valid", 32'(rd_valid), 0);
    check("reset_level", 32'(fifo_level), 0);
    check("reset_head", 32'({rd_ext, rd_brk, rd_code}), 0);
    check("reset_errs", 32'({frame_err, timeout_err, overflow}), 0);

    // Single 1C frame: latency to rd_valid with the FIFO empty.
    model_frame(8'h1C, 0, 0);
    send_bits(mk_frame(8'h1C, 0, 0), 11, 0, lat);
    check("latency_1C", 32'(lat), 32'(2 + FILTER_LEN + 3));
    check("head_1C", 32'({rd_ext, rd_brk, rd_code}), 32'(exp_q[0]));
    ps2_data = 1'b1;
    repeat (IDLE_GAP) @(negedge ck);
    set_ready(1'b1);
    wait_drain("drain_1C");
    check("no_err_1C", 32'(n_fe + n_to), 0);

    // Prefix folding.
    send_frame(8'hE0, 0, 0, 0, lat);
    send_frame(8'hF0, 0, 0, 0, lat);
    send_frame(8'h75, 0, 0, 0, lat);
    send_frame(8'h1C, 0, 0, 0, lat);
    wait_drain("drain_prefix");

    // Parity flipped.
    send_frame(8'h24, 1, 0, 0, lat);
    wait_drain("drain_parity");
    check("frame_err_parity", 32'(n_fe), 32'(exp_fe));

    // Timeout with an E0 pending; the flag must not leak into the next code.
    send_frame(8'hE0, 0, 0, 0, lat);
    send_bits(mk_frame(8'h16, 0, 0), 5, 0, lat);
    exp_to++;
    m_ext = 0;
    m_brk = 0;
    ps2_data = 1'b1;
    repeat ((TIMEOUT_US + 10) * CYC_PER_US) @(negedge ck);
    check("timeout_count", 32'(n_to), 32'(exp_to));
    send_frame(8'h16, 0, 0, 0, lat);
    wait_drain("drain_timeout");

    // Clock glitches.
    send_frame(8'h3A, 0, 0, 1, lat);
    send_frame(8'hA5, 0, 0, 1, lat);
    wait_drain("drain_glitch");

    // Randomised traffic with random back-pressure.
    ready_mode = 1;
    for (int k = 0; k < 30; k++) begin
      int kind;
      logic [7:0] c;
      kind = int'($urandom_range(0, 9));
      c = 8'($urandom);
      case (kind)
        0:       send_frame(8'hE0, 0, 0, 0, lat);
        1:       send_frame(8'hF0, 0, 0, 0, lat);
        2:       send_frame(c, 1, 0, 0, lat);
        3:       send_frame(c, 0, 1, 0, lat);
        default: send_frame(c, 0, 0, 0, lat);
      endcase
    end
    ready_mode = 0;
    set_ready(1'b1);
    wait_drain("drain_random");
    check("frame_err_random", 32'(n_fe), 32'(exp_fe));

    // Reset in the middle of a frame discards it.
    send_bits(mk_frame(8'h5A, 0, 0), 6, 0, lat);
    @(posedge ck);
    #1 reset_n = 1'b0;
    m_ext = 0;
    m_brk = 0;
    repeat (3) @(negedge ck);
    @(posedge ck);
    #1 reset_n = 1'b1;
    repeat (2 * HALF) @(negedge ck);
    check("midreset_level", 32'(fifo_level), 0);
    send_frame(8'h33, 0, 0, 0, lat);
    wait_drain("drain_midreset");

    // Overflow with the consumer stalled.
    set_ready(1'b0);
    for (int k = 0; k < 5; k++) send_frame(ovf_codes[k], 0, 0, 0, lat);
    check("ovf_level", 32'(fifo_level), 32'(exp_q.size()));
    check("ovf_flag", 32'(overflow), 32'(exp_ovf));
    check("ovf_head", 32'(rd_code), 32'(exp_q[0][7:0]));
    set_ready(1'b1);
    wait_drain("drain_ovf");
    check("ovf_sticky", 32'(overflow), 32'(exp_ovf));
    @(posedge ck);
    #1 reset_n = 1'b0;
    @(posedge ck);
    #1 reset_n = 1'b1;
    @(negedge ck);
    check("ovf_cleared", 32'(overflow), 0);

    check("final_level", 32'(fifo_level), 0);
    check("final_frame_err", 32'(n_fe), 32'(exp_fe));
    check("final_timeout_err", 32'(n_to), 32'(exp_to));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
